// File: rtl/lz77_stream_matcher.sv
// Sliding-window LZ77 match engine: buffers a lookahead, scans history distances one per
// cycle, and emits one literal or (distance, length) token per step over valid/ready.
module lz77_stream_matcher #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WIN_DEPTH = 16,
    parameter int unsigned LA_DEPTH  = 8,
    parameter int unsigned MIN_MATCH = 3,
    localparam int unsigned OFF_W    = $clog2(WIN_DEPTH),
    localparam int unsigned LEN_RAW  = $clog2(LA_DEPTH - MIN_MATCH + 1),
    localparam int unsigned LEN_W    = (LEN_RAW > 1) ? LEN_RAW : 1,
    localparam int unsigned TOK_W    = 1 + ((DATA_W > OFF_W + LEN_W) ? DATA_W : OFF_W + LEN_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [TOK_W-1:0]  tok_data,
    output logic              tok_last,
    output logic              done
);

    localparam int unsigned CNT_W  = $clog2(WIN_DEPTH + 1);
    localparam int unsigned LCNT_W = $clog2(LA_DEPTH + 1);
    localparam int unsigned LA_IW  = $clog2(LA_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SEARCH,
        S_EMIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   hist [WIN_DEPTH];
    logic [DATA_W-1:0]   la   [LA_DEPTH];
    logic [CNT_W-1:0]    hist_cnt;
    logic [LCNT_W-1:0]   la_cnt;
    logic                last_seen;
    logic [CNT_W-1:0]    cand_d;
    logic [CNT_W-1:0]    best_d;
    logic [LCNT_W-1:0]   best_len;
    logic [LCNT_W-1:0]   shift_cnt;

    logic                accept_c;
    logic [LCNT_W-1:0]   fill_cnt_c;
    logic                fill_last_c;
    logic [LCNT_W-1:0]   la_dec_c;
    logic [LCNT_W-1:0]   cand_len_c;
    logic                cand_run_c;
    logic [LCNT_W-1:0]   sel_len_c;
    logic [CNT_W-1:0]    sel_d_c;
    logic [TOK_W-1:0]    emit_tok_c;
    logic [LCNT_W-1:0]   emit_n_c;
    logic                emit_last_c;
    logic                search_end_c;

    always_comb begin
        accept_c    = (state == S_FILL) && in_valid && in_ready;
        fill_cnt_c  = la_cnt + LCNT_W'(accept_c);
        fill_last_c = last_seen || (accept_c && in_last);
        la_dec_c    = la_cnt - LCNT_W'(1);
    end

    // Leading-run length at distance cand_d, capped by the distance (no overlap) and la_cnt
    always_comb begin
        cand_len_c = '0;
        cand_run_c = 1'b1;
        for (int k = 0; k < int'(LA_DEPTH); k++) begin
            if (cand_run_c && (k < int'(la_cnt)) && (k < int'(cand_d)) &&
                (la[k] == hist[OFF_W'(int'(cand_d) - k - 1)])) begin
                cand_len_c = cand_len_c + LCNT_W'(1);
            end else begin
                cand_run_c = 1'b0;
            end
        end
    end

    // Strictly-greater update keeps the smallest distance on ties
    always_comb begin
        sel_len_c = best_len;
        sel_d_c   = best_d;
        if ((hist_cnt != '0) && (cand_len_c > best_len)) begin
            sel_len_c = cand_len_c;
            sel_d_c   = cand_d;
        end
        emit_tok_c = '0;
        emit_n_c   = LCNT_W'(1);
        if (sel_len_c >= LCNT_W'(MIN_MATCH)) begin
            emit_tok_c[TOK_W-1]               = 1'b1;
            emit_tok_c[OFF_W+LEN_W-1:LEN_W]   = OFF_W'(sel_d_c - CNT_W'(1));
            emit_tok_c[LEN_W-1:0]             = LEN_W'(sel_len_c - LCNT_W'(MIN_MATCH));
            emit_n_c                          = sel_len_c;
        end else begin
            emit_tok_c[DATA_W-1:0] = la[0];
        end
        emit_last_c  = last_seen && (emit_n_c == la_cnt);
        search_end_c = (hist_cnt == '0) || (cand_len_c == la_cnt) || (cand_d == hist_cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            tok_valid <= 1'b0;
            tok_data  <= '0;
            tok_last  <= 1'b0;
            done      <= 1'b0;
            hist_cnt  <= '0;
            la_cnt    <= '0;
            last_seen <= 1'b0;
            cand_d    <= '0;
            best_d    <= '0;
            best_len  <= '0;
            shift_cnt <= '0;
            for (int i = 0; i < int'(WIN_DEPTH); i++) hist[i] <= '0;
            for (int i = 0; i < int'(LA_DEPTH); i++) la[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        hist_cnt  <= '0;
                        la_cnt    <= '0;
                        last_seen <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (accept_c) begin
                        la[LA_IW'(la_cnt)] <= in_data;
                        la_cnt             <= fill_cnt_c;
                        last_seen          <= fill_last_c;
                    end
                    if ((fill_cnt_c == LCNT_W'(LA_DEPTH)) || (fill_last_c && (fill_cnt_c != '0))) begin
                        in_ready <= 1'b0;
                        best_len <= '0;
                        best_d   <= '0;
                        cand_d   <= CNT_W'(1);
                        state    <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (search_end_c) begin
                        tok_valid <= 1'b1;
                        tok_data  <= emit_tok_c;
                        tok_last  <= emit_last_c;
                        shift_cnt <= emit_n_c;
                        state     <= S_EMIT;
                    end else begin
                        best_len <= sel_len_c;
                        best_d   <= sel_d_c;
                        cand_d   <= cand_d + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (tok_ready) begin
                        tok_valid <= 1'b0;
                        tok_last  <= 1'b0;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Oldest history byte falls off the far end of the window
                    for (int i = int'(WIN_DEPTH) - 1; i > 0; i--) hist[i] <= hist[i-1];
                    hist[0] <= la[0];
                    for (int i = 0; i < int'(LA_DEPTH) - 1; i++) la[i] <= la[i+1];
                    la_cnt    <= la_dec_c;
                    shift_cnt <= shift_cnt - LCNT_W'(1);
                    if (hist_cnt != CNT_W'(WIN_DEPTH)) hist_cnt <= hist_cnt + CNT_W'(1);
                    if (shift_cnt == LCNT_W'(1)) begin
                        if ((la_dec_c == '0) && last_seen) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (!last_seen) begin
                            in_ready <= 1'b1;
                            state    <= S_FILL;
                        end else begin
                            best_len <= '0;
                            best_d   <= '0;
                            cand_d   <= CNT_W'(1);
                            state    <= S_SEARCH;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_stream_matcher.sv
// Directed and randomized frames for lz77_stream_matcher, checked against a
// position-based LZ77 reference model of the token stream.
module tb_lz77_stream_matcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       tok_valid;
    logic       tok_ready;
    logic [8:0] tok_data;
    logic       tok_last;
    logic       done;

    lz77_stream_matcher dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .tok_valid(tok_valid),
        .tok_ready(tok_ready),
        .tok_data (tok_data),
        .tok_last (tok_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [7:0] stim[$];
    logic [8:0] exp_tok[$];
    bit         exp_last[$];
    int         exp_n[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // At each stream position: lookahead is the next min(8, remaining) bytes, history the
    // previous min(pos, 16) bytes; pick the longest non-overlapping run, smallest distance.
    task automatic build_model();
        int n_tot, pos, la_len, h_len, bl, bd, len, n;
        exp_tok.delete();
        exp_last.delete();
        exp_n.delete();
        n_tot = stim.size();
        pos = 0;
        while (pos < n_tot) begin
            la_len = (n_tot - pos < 8) ? n_tot - pos : 8;
            h_len  = (pos < 16) ? pos : 16;
            bl = 0;
            bd = 0;
            for (int d = 1; d <= h_len; d++) begin
                len = 0;
                while (len < d && len < la_len && stim[pos+len] == stim[pos-d+len]) len++;
                if (len > bl) begin
                    bl = len;
                    bd = d;
                end
            end
            if (bl >= 3) begin
                exp_tok.push_back(9'(256 + (bd - 1) * 8 + (bl - 3)));
                n = bl;
            end else begin
                exp_tok.push_back({1'b0, stim[pos]});
                n = 1;
            end
            exp_n.push_back(n);
            exp_last.push_back(pos + n == n_tot);
            pos += n;
        end
    endtask

    // mode: 0 ready always, 1 ready toggling, 2 random ready and in_valid gaps,
    // 3 ready never and return as soon as the first token is presented
    task automatic run_frame(input int mode, input int starve_pos);
        int   n_tot, bi, ti, cyc, hs_cyc, n_last, starve_cnt;
        bit   done_seen, held, got_tok;
        logic [8:0] held_data;
        build_model();
        n_tot = stim.size();
        bi = 0; ti = 0; cyc = 0; hs_cyc = 0; n_last = 0; starve_cnt = 0;
        done_seen = 0; held = 0; got_tok = 0; held_data = '0;
        @(negedge clk);
        start = 1'b1;
        while (!done_seen && !got_tok && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done === 1'b1) begin
                check("done_latency", cyc, hs_cyc + 1 + n_last);
                check("done_token_count", ti, exp_tok.size());
                done_seen = 1;
            end
            if (held) begin
                check("held_valid", tok_valid, 1'b1);
                check("held_data", tok_data, held_data);
            end
            if (bi == n_tot) check("in_ready_after_last", in_ready, 1'b0);
            if (mode == 3 && tok_valid === 1'b1) begin
                check("abort_first_tok", tok_data, exp_tok[0]);
                got_tok = 1;
                in_valid = 1'b0;
                tok_ready = 1'b0;
                break;
            end
            case (mode)
                0:       tok_ready = 1'b1;
                1:       tok_ready = cyc[0];
                2:       tok_ready = ($urandom_range(0, 2) != 0);
                default: tok_ready = 1'b0;
            endcase
            if (starve_pos >= 0 && bi == starve_pos && starve_cnt < 5) begin
                starve_cnt++;
                in_valid = 1'b0;
                check("starve_tok_valid", tok_valid, 1'b0);
                check("starve_in_ready", in_ready, 1'b1);
            end else begin
                in_valid = (bi < n_tot) && (mode != 2 || $urandom_range(0, 3) != 0);
            end
            in_data = (bi < n_tot) ? stim[bi] : 8'h00;
            in_last = (bi == n_tot - 1);
            if (in_valid && in_ready === 1'b1) bi++;
            if (tok_valid === 1'b1 && tok_ready) begin
                check("tok_in_range", ti < exp_tok.size(), 1'b1);
                if (ti < exp_tok.size()) begin
                    check("tok_data", tok_data, exp_tok[ti]);
                    check("tok_last", tok_last, exp_last[ti]);
                    n_last = exp_n[ti];
                end
                hs_cyc = cyc;
                held = 0;
                ti++;
            end else if (tok_valid === 1'b1) begin
                held = 1;
                held_data = tok_data;
            end else begin
                held = 0;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        tok_ready = 1'b0;
        if (mode == 3) begin
            check("abort_tok_seen", got_tok, 1'b1);
        end else begin
            check("frame_done", done_seen, 1'b1);
            @(negedge clk);
            check("done_single_pulse", done, 1'b0);
            check("idle_tok_valid", tok_valid, 1'b0);
        end
    endtask

    task automatic load_abc();
        stim.delete();
        for (int r = 0; r < 3; r++) begin
            stim.push_back(8'h41);
            stim.push_back(8'h42);
            stim.push_back(8'h43);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        tok_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_tok_valid", tok_valid, 1'b0);
        check("rst_tok_data", tok_data, 9'h000);
        check("rst_tok_last", tok_last, 1'b0);
        check("rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Repeated ABC: three literals then two distance-3 matches
        load_abc();
        run_frame(0, -1);

        // Single byte frame
        stim.delete();
        stim.push_back(8'h5a);
        run_frame(0, -1);

        // Distance 20 lies beyond the window, so all literals
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(8'(i));
        stim.push_back(8'h00);
        stim.push_back(8'h01);
        stim.push_back(8'h02);
        run_frame(0, -1);

        // Run of identical bytes, with steady and toggling tok_ready
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(8'h77);
        run_frame(0, -1);
        run_frame(1, -1);

        // Reset while a token is presented aborts the frame asynchronously
        load_abc();
        run_frame(3, -1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_tok_valid", tok_valid, 1'b0);
        check("abort_tok_data", tok_data, 9'h000);
        check("abort_tok_last", tok_last, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stim.delete();
        stim.push_back(8'h41);
        stim.push_back(8'h42);
        run_frame(0, -1);

        // Input starvation in the middle of the first fill
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(8'($urandom_range(0, 2)));
        run_frame(0, 3);

        // Random frames over a small alphabet so matches and window wrap are frequent
        for (int r = 0; r < 9; r++) begin
            int len;
            len = $urandom_range(1, 60);
            stim.delete();
            for (int i = 0; i < len; i++) stim.push_back(8'($urandom_range(0, 3)));
            run_frame(r % 3, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
